// File: rtl/dcmi_mux_tx.sv
// Round-robin multi-source DCMI frame transmitter: one granted packet per VSYNC frame.
// Optional DCMI_MUX_HDR_EN prefixes each non-empty frame with header byte {4'hA, src}.
module dcmi_mux_tx #(
    parameter int N_SRC     = 2,
    parameter int CLK_DIV   = 4,
    parameter int GAP_SLOTS = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] DREQ,
    output logic [N_SRC-1:0] DACK,
    input  logic [7:0]       MDATA,
    output logic             DCLKEN,
    output logic [7:0]       DCMI_D,
    output logic             DCMI_PCLK,
    output logic             DCMI_HSYNC,
    output logic             DCMI_VSYNC,
    output logic             BUSY
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
`ifdef DCMI_MUX_HDR_EN
    localparam logic [2:0] S_HDR   = 3'd2;
`endif
    localparam logic [2:0] S_XFER  = 3'd3;
    localparam logic [2:0] S_TAIL  = 3'd4;

    logic [DW-1:0]    div_q, div_d;
    logic             pclk_q;
    logic [2:0]       state_q, state_d;
    logic [IW-1:0]    g_q, g_d;
    logic [IW-1:0]    last_q, last_d;
    logic [N_SRC-1:0] dack_q, dack_d;
    logic [7:0]       data_q, data_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [GW-1:0]    gap_q, gap_d;

    logic             slot_end;
    logic             req_g;
    logic             take;
    logic             rr_hit;
    logic [IW-1:0]    rr_idx;
    logic [IW-1:0]    cand;

    assign slot_end = (div_q == DW'(CLK_DIV - 1));
    assign div_d    = slot_end ? '0 : div_q + 1'b1;
    assign req_g    = DREQ[g_q];

    // Search starts just after the previous winner so every source gets a turn.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cand = IW'((int'(last_q) + 1 + i) % N_SRC);
            if (!rr_hit && DREQ[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        dack_d  = dack_q;
        data_d  = data_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        gap_d   = gap_q;
        take    = 1'b0;
        if (slot_end) begin
            case (state_q)
                S_IDLE: begin
                    if (rr_hit) begin
                        g_d            = rr_idx;
                        last_d         = rr_idx;
                        dack_d         = '0;
                        dack_d[rr_idx] = 1'b1;
                        vs_d           = 1'b1;
                        state_d        = S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (req_g) begin
`ifdef DCMI_MUX_HDR_EN
                        data_d  = {4'hA, 4'(g_q)};
                        hs_d    = 1'b1;
                        state_d = S_HDR;
`else
                        take    = 1'b1;
                        data_d  = MDATA;
                        hs_d    = 1'b1;
                        state_d = S_XFER;
`endif
                    end else begin
                        vs_d    = 1'b0;
                        dack_d  = '0;
                        gap_d   = '0;
                        state_d = S_TAIL;
                    end
                end
`ifdef DCMI_MUX_HDR_EN
                S_HDR,
`endif
                S_XFER: begin
                    // Source drops DREQ with its last DCLKEN, so a low here means done.
                    if (req_g) begin
                        take    = 1'b1;
                        data_d  = MDATA;
                        state_d = S_XFER;
                    end else begin
                        hs_d    = 1'b0;
                        vs_d    = 1'b0;
                        dack_d  = '0;
                        data_d  = '0;
                        gap_d   = '0;
                        state_d = S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (gap_q == GW'(GAP_SLOTS - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    dack_d  = '0;
                    hs_d    = 1'b0;
                    vs_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q   <= '0;
            pclk_q  <= 1'b0;
            state_q <= S_IDLE;
            g_q     <= '0;
            last_q  <= IW'(N_SRC - 1);
            dack_q  <= '0;
            data_q  <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            gap_q   <= '0;
        end else begin
            div_q   <= div_d;
            pclk_q  <= (div_d >= DW'(CLK_DIV / 2));
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            dack_q  <= dack_d;
            data_q  <= data_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            gap_q   <= gap_d;
        end
    end

    assign DACK       = dack_q;
    assign DCLKEN     = take;
    assign DCMI_D     = data_q;
    assign DCMI_PCLK  = pclk_q;
    assign DCMI_HSYNC = hs_q;
    assign DCMI_VSYNC = vs_q;
    assign BUSY       = (state_q != S_IDLE);

endmodule
